// File: rtl/ibfly_pkg.sv
// Shared types and helpers for the inverse-butterfly pext control generator.
// Holds widths, stage count, cfg/rotation types, FSM state and popcount.
package ibfly_pkg;

  localparam int XLEN      = 32;
  localparam int STAGE_CNT = 5;

  typedef logic [15:0] ibfly_cfg_t;
  typedef logic [3:0]  ibfly_rot_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } ibfly_state_e;

  function automatic logic [5:0] popcnt32(
    input logic [31:0] v
  );
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/ibfly_cfg_stage.sv
// One inverse-butterfly stage of pext control: cfg bits for stage s plus
// the rotation array handed down to stage s-1. Purely combinational.
module ibfly_cfg_stage
  import ibfly_pkg::*;
(
  input  logic [2:0]        s,
  input  logic [31:0]       mask,
  input  ibfly_rot_t [15:0] rot,
  output ibfly_cfg_t        cfg,
  output ibfly_rot_t [15:0] rot_nxt
);

  int h;
  int m2;
  int k;
  int r;
  int idx;
  int j;

  always_comb begin
    cfg     = '0;
    rot_nxt = '0;
    k       = 0;
    r       = 0;
    idx     = 0;
    j       = 0;
    h       = 1 << s;
    m2      = 2 * h - 1;
    for (int b = 0; b < 16; b++) begin
      // 16/h blocks of 2h bits are live this stage
      if (b * h < 16) begin
        k = 0;
        for (int i = 0; i < 16; i++) begin
          if (i < h) begin
            idx = b * 2 * h + i;
            k   = k + (mask[idx[4:0]] ? 1 : 0);
          end
        end
        r = int'(rot[b[3:0]]) & m2;
        for (int o = 0; o < 16; o++) begin
          if (o < h) begin
            idx = b * h + o;
            cfg[idx[3:0]] = ((o - r - k) & m2) < h;
          end
        end
        // children only exist above stage 0
        if (2 * b + 1 < 16) begin
          j = 2 * b;
          rot_nxt[j[3:0]] = ibfly_rot_t'(r & (h - 1));
          j = 2 * b + 1;
          rot_nxt[j[3:0]] = ibfly_rot_t'((r + k) & (h - 1));
        end
      end
    end
  end

endmodule

// File: rtl/ibfly_pext_cfg_gen_32.sv
// Iterative pext configuration generator for the 32-bit inverse butterfly.
// in_*: mask/data request; out_*: cfg0..cfg4, masked data, popcount, rmask.
module ibfly_pext_cfg_gen_32 #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_mask,
  input  logic [XLEN-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     cfg0,
  output logic [15:0]     cfg1,
  output logic [15:0]     cfg2,
  output logic [15:0]     cfg3,
  output logic [15:0]     cfg4,
  output logic [XLEN-1:0] out_data,
  output logic [5:0]      out_cnt,
  output logic [XLEN-1:0] out_rmask
);

  import ibfly_pkg::*;

  if (XLEN != 32) begin : g_xlen_chk
    $error("ibfly_pext_cfg_gen_32 supports XLEN=32 only");
  end

  ibfly_state_e      state;
  logic [2:0]        s_q;
  logic [31:0]       mask_q;
  ibfly_rot_t [15:0] rot_q;
  ibfly_cfg_t        cfg_q [STAGE_CNT];
  logic [31:0]       data_q;
  logic [5:0]        cnt_q;
  logic [31:0]       rmask_q;

  ibfly_cfg_t        stage_cfg;
  ibfly_rot_t [15:0] rot_nxt;
  logic [5:0]        in_cnt;
  logic [31:0]       in_rmask;

  ibfly_cfg_stage u_stage (
    .s       (s_q),
    .mask    (mask_q),
    .rot     (rot_q),
    .cfg     (stage_cfg),
    .rot_nxt (rot_nxt)
  );

  assign in_cnt   = popcnt32(in_mask);
  assign in_rmask = in_cnt[5] ? '1
                  : (32'd1 << in_cnt) - 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      s_q     <= '0;
      mask_q  <= '0;
      rot_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      rmask_q <= '0;
      for (int i = 0; i < STAGE_CNT; i++) begin
        cfg_q[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mask_q  <= in_mask;
            data_q  <= in_data & in_mask;
            cnt_q   <= in_cnt;
            rmask_q <= in_rmask;
            s_q     <= 3'd4;
            rot_q   <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          for (int i = 0; i < STAGE_CNT; i++) begin
            if (s_q == 3'(i)) begin
              cfg_q[i] <= stage_cfg;
            end
          end
          rot_q <= rot_nxt;
          if (s_q == 3'd0) begin
            state <= DONE;
          end else begin
            s_q <= s_q - 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign cfg0      = cfg_q[0];
  assign cfg1      = cfg_q[1];
  assign cfg2      = cfg_q[2];
  assign cfg3      = cfg_q[3];
  assign cfg4      = cfg_q[4];
  assign out_data  = data_q;
  assign out_cnt   = cnt_q;
  assign out_rmask = rmask_q;

endmodule
